// File: rtl/cf_fft_1024_8_10_pair.sv
// Input pairing stage for the radix-2 butterfly: buffers half a block, then emits (a, b) pairs
// with twiddle index and enable; also generates the 4-cycle drain burst on flush.
module cf_fft_1024_8_10_pair #(
    parameter int unsigned LOG2_DEPTH = 3
) (
    input  logic        clock_c,
    input  logic        i1,
    input  logic [15:0] i2,
    input  logic        i3,
    input  logic        i4,
    output logic [15:0] o1,
    output logic [15:0] o2,
    output logic [2:0]  o3,
    output logic        o4,
    output logic        o5
);

    localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;

    typedef enum logic [1:0] {StFill, StPair, StDrain} state_e;

    state_e                state_q, state_d;
    logic [LOG2_DEPTH-1:0] k_q, k_d;
    logic [1:0]            drain_q, drain_d;
    logic [15:0]           mem_q [DEPTH];

    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [2:0]  tw_q, tw_d;
    logic        en_q, en_d;

    logic k_last;
    logic flush_go;
    logic fill_wr;

    assign k_last   = &k_q;
    // Flush is only honoured when idle; it takes priority over a coincident sample.
    assign flush_go = (state_q == StFill) && (k_q == '0) && i4;
    assign fill_wr  = (state_q == StFill) && i3 && !flush_go && !i1;

    // State register
    always_ff @(posedge clock_c) begin
        if (i1) begin
            state_q <= StFill;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drain_q <= drain_d;
        end
    end

    // Half-block buffer, deliberately not reset
    always_ff @(posedge clock_c) begin
        if (fill_wr) begin
            mem_q[k_q] <= i2;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drain_d = drain_q;
        unique case (state_q)
            StFill: begin
                if (flush_go) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else if (i3) begin
                    k_d = k_q + 1'b1;
                    if (k_last) begin
                        state_d = StPair;
                    end
                end
            end
            StPair: begin
                if (i3) begin
                    k_d = k_q + 1'b1;
                    if (k_last) begin
                        state_d = StFill;
                    end
                end
            end
            StDrain: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == 2'd3) begin
                    state_d = StFill;
                    k_d     = '0;
                end
            end
            default: begin
                state_d = StFill;
                k_d     = '0;
            end
        endcase
    end

    // Output next-value logic; pair outputs hold while no pair is issued
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        tw_d = tw_q;
        en_d = 1'b0;
        unique case (state_q)
            StFill: begin
                if (flush_go) begin
                    a_d  = '0;
                    b_d  = '0;
                    tw_d = '0;
                    en_d = 1'b1;
                end
            end
            StPair: begin
                if (i3) begin
                    a_d  = mem_q[k_q];
                    b_d  = i2;
                    tw_d = k_q[LOG2_DEPTH-1 -: 3];
                    en_d = 1'b1;
                end
            end
            StDrain: begin
                a_d  = '0;
                b_d  = '0;
                tw_d = '0;
                en_d = (drain_q != 2'd3);
            end
            default: begin
                en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_c) begin
        if (i1) begin
            a_q  <= '0;
            b_q  <= '0;
            tw_q <= '0;
            en_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            tw_q <= tw_d;
            en_q <= en_d;
        end
    end

    assign o1 = a_q;
    assign o2 = b_q;
    assign o3 = tw_q;
    assign o4 = en_q;
    assign o5 = (state_q != StFill);

endmodule

// File: tb/tb_cf_fft_1024_8_10_pair.sv
// Bench for the pairing stage: two instances (depth 8 and 32) share one stimulus stream and are
// checked every cycle against a block-level reference model.
module tb_cf_fft_1024_8_10_pair;

    logic        clk = 1'b0;
    logic        rst, vld, flush;
    logic [15:0] din;

    logic [15:0] q1 [2];
    logic [15:0] q2 [2];
    logic [2:0]  q3 [2];
    logic        q4 [2];
    logic        q5 [2];

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Reference model state: 0 = fill, 1 = pair, 2 = drain
    int          m_st  [2];
    int          m_k   [2];
    int          m_cnt [2];
    logic [15:0] m_buf [2][32];
    logic [15:0] e1 [2];
    logic [15:0] e2 [2];
    logic [2:0]  e3 [2];
    logic        e4 [2];

    always #5 clk = ~clk;

    cf_fft_1024_8_10_pair #(.LOG2_DEPTH(3)) u_dut8 (
        .clock_c(clk), .i1(rst), .i2(din), .i3(vld), .i4(flush),
        .o1(q1[0]), .o2(q2[0]), .o3(q3[0]), .o4(q4[0]), .o5(q5[0])
    );

    cf_fft_1024_8_10_pair #(.LOG2_DEPTH(5)) u_dut32 (
        .clock_c(clk), .i1(rst), .i2(din), .i3(vld), .i4(flush),
        .o1(q1[1]), .o2(q2[1]), .o3(q3[1]), .o4(q4[1]), .o5(q5[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input int d);
        int depth;
        depth = (d == 0) ? 8 : 32;
        if (rst) begin
            m_st[d] = 0; m_k[d] = 0; m_cnt[d] = 0;
            e1[d] = '0; e2[d] = '0; e3[d] = '0; e4[d] = 1'b0;
        end else if (m_st[d] == 2) begin
            if (m_cnt[d] == 4) begin
                m_st[d] = 0;
                m_k[d]  = 0;
                e4[d]   = 1'b0;
            end else begin
                m_cnt[d]++;
                e4[d] = 1'b1;
            end
        end else if (m_st[d] == 1) begin
            if (vld) begin
                e1[d] = m_buf[d][m_k[d]];
                e2[d] = din;
                e3[d] = 3'(m_k[d] * 8 / depth);
                e4[d] = 1'b1;
                m_k[d] = (m_k[d] + 1) % depth;
                if (m_k[d] == 0) m_st[d] = 0;
            end else begin
                e4[d] = 1'b0;
            end
        end else begin
            e4[d] = 1'b0;
            if (flush && m_k[d] == 0) begin
                m_st[d] = 2; m_cnt[d] = 1;
                e1[d] = '0; e2[d] = '0; e3[d] = '0; e4[d] = 1'b1;
            end else if (vld) begin
                m_buf[d][m_k[d]] = din;
                m_k[d] = (m_k[d] + 1) % depth;
                if (m_k[d] == 0) m_st[d] = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("o1[%0d]", d), 32'(q1[d]), 32'(e1[d]));
                chk($sformatf("o2[%0d]", d), 32'(q2[d]), 32'(e2[d]));
                chk($sformatf("o3[%0d]", d), 32'(q3[d]), 32'(e3[d]));
                chk($sformatf("o4[%0d]", d), 32'(q4[d]), 32'(e4[d]));
                chk($sformatf("o5[%0d]", d), 32'(q5[d]), 32'(m_st[d] != 0));
            end
        end
    end

    task automatic cyc(input logic r, input logic v, input logic f, input logic [15:0] d);
        rst = r; vld = v; flush = f; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        started = 1'b1;
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; flush = 1'b0; din = '0;

        // Continuous ramp
        do_reset();
        chk("reset_o4", 32'(q4[0]), 32'd0);
        chk("reset_o5", 32'(q5[0]), 32'd0);
        for (int n = 0; n < 16; n++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'(16'h0100 + n));
            if (n == 7) chk("fill_no_o4", 32'(q4[0]), 32'd0);
            if (n == 8) begin
                chk("pair0_o1", 32'(q1[0]), 32'h0100);
                chk("pair0_o2", 32'(q2[0]), 32'h0108);
                chk("pair0_o4", 32'(q4[0]), 32'd1);
            end
            if (n == 15) begin
                chk("pair7_o1", 32'(q1[0]), 32'h0107);
                chk("pair7_o2", 32'(q2[0]), 32'h010f);
                chk("pair7_o3", 32'(q3[0]), 32'd7);
                chk("pair7_o5", 32'(q5[0]), 32'd0);
            end
        end

        // Gapped ramp
        do_reset();
        for (int n = 0; n < 16; n++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'(16'h0100 + n));
            cyc(1'b0, 1'b0, 1'b0, 16'hdead);
            if (n == 9) begin
                chk("gap_hold_o4", 32'(q4[0]), 32'd0);
                chk("gap_hold_o1", 32'(q1[0]), 32'h0101);
            end
        end

        // Full block, then flush burst, then another block
        do_reset();
        for (int n = 0; n < 16; n++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0);
        chk("drain_o4", 32'(q4[0]), 32'd1);
        chk("drain_o5", 32'(q5[0]), 32'd1);
        chk("drain_o1", 32'(q1[0]), 32'd0);
        for (int n = 0; n < 3; n++) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("drain_last_o4", 32'(q4[0]), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("drain_end_o4", 32'(q4[0]), 32'd0);
        chk("drain_end_o5", 32'(q5[0]), 32'd0);
        for (int n = 0; n < 16; n++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom));

        // Flush mid-fill ignored; flush with sample while idle drops the sample
        do_reset();
        for (int n = 0; n < 3; n++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
        cyc(1'b0, 1'b0, 1'b1, 16'h0);
        chk("midfill_flush_o4", 32'(q4[0]), 32'd0);
        for (int n = 0; n < 13; n++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
        cyc(1'b0, 1'b1, 1'b1, 16'hbeef);
        chk("flush_wins_o4", 32'(q4[0]), 32'd1);
        for (int n = 0; n < 4; n++) cyc(1'b0, 1'b1, 1'b0, 16'hbeef);
        for (int n = 0; n < 16; n++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom));

        // Reset in the middle of pairing
        do_reset();
        for (int n = 0; n < 13; n++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        chk("midpair_rst_o4", 32'(q4[0]), 32'd0);
        chk("midpair_rst_o1", 32'(q1[0]), 32'd0);
        chk("midpair_rst_o5", 32'(q5[0]), 32'd0);
        for (int n = 0; n < 16; n++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom));

        // 64-sample ramp for the depth-32 instance
        do_reset();
        for (int n = 0; n < 64; n++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'(n));
            if (n == 35) chk("d32_pair3_o3", 32'(q3[1]), 32'd0);
            if (n == 36) chk("d32_pair4_o3", 32'(q3[1]), 32'd1);
            if (n == 63) begin
                chk("d32_pair31_o3", 32'(q3[1]), 32'd7);
                chk("d32_pair31_o1", 32'(q1[1]), 32'd31);
            end
        end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 19) == 0), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
